dft_sweep_ctrl: RTL and testbench
=================================

Name: dft_sweep_ctrl

Overview:
- Frame-level sequencer for the single-bin DFT engine.
- Buffers one frame of N real samples, then sweeps bins k = 0..N-1.
- For each bin it clears the engine, streams the frame into it, waits for done, and presents the scaled complex result on a valid/ready output.
- Sits between the sample source (ADC/SPI front end) and downstream result consumer, alongside one engine instance.

Parameters:
WIDTH, 16, sample/result/index width (signed two's complement)
N_MAX, 1024, maximum frame length; sample buffer depth
LOG_N_MAX, 10, log2(N_MAX)
FRAC_BITS, 6, fractional bits removed from engine result (arithmetic shift right)
WAIT_MAX, 4096, cycles allowed in WAIT before timeout

Ports:
i_sys_clk  in  1  system clock
i_reset  in  1  asynchronous active-high reset
i_start  in  1  start pulse, sampled only in IDLE
i_N  in  WIDTH  frame length, latched on accepted start
i_s_valid  in  1  sample valid
i_s_data  in  WIDTH  sample
o_s_ready  out  1  sample ready (high only in LOAD)
o_eng_rst  out  1  engine clear, one-cycle pulse per bin
o_eng_wr  out  1  engine sample write strobe
o_eng_x  out  WIDTH  engine sample
o_eng_n  out  WIDTH  engine sample index
o_eng_k  out  WIDTH  engine bin index
o_eng_N  out  WIDTH  engine frame length (latched N)
i_eng_done  in  1  engine result valid
i_eng_X_re  in  WIDTH  engine result, real
i_eng_X_im  in  WIDTH  engine result, imaginary
o_bin_valid  out  1  result valid
i_bin_ready  in  1  result ready
o_bin_k  out  WIDTH  bin index of result
o_bin_re  out  WIDTH  i_eng_X_re >>> FRAC_BITS
o_bin_im  out  WIDTH  i_eng_X_im >>> FRAC_BITS
o_busy  out  1  high in every state except IDLE
o_frame_done  out  1  one-cycle pulse after last bin handshake
o_err  out  1  one-cycle pulse on rejected start or timeout

Behaviour:
- Reset: the only reset is the asynchronous active-high i_reset; it is not synchronised internally.
- Reset values:
  - state = IDLE.
  - All outputs 0, except o_eng_N = 0 and o_s_ready = 0.
  - Counters cleared. Buffer contents undefined.
- Outputs: all registered.
- IDLE:
  - If i_start and 1 <= i_N <= N_MAX: latch N, set n = 0, go to LOAD.
  - If i_start and (i_N == 0, i_N > N_MAX, or i_N negative): pulse o_err, stay in IDLE.
- LOAD:
  - o_s_ready = 1.
  - On each i_s_valid & o_s_ready: buf[n] <= i_s_data, n++.
  - On handshake with n == N-1: set k = 0 and go to CLR.
  - There is no timeout in LOAD.
- CLR:
  - o_eng_rst = 1 for exactly one cycle; n = 0; go to FEED.
- FEED:
  - For N consecutive cycles: o_eng_wr = 1, with o_eng_n = n and o_eng_x = buf[n] aligned in the same cycle.
  - Synchronous buffer read is prefetched so there are no gaps.
  - After the n = N-1 cycle: o_eng_wr = 0, go to WAIT.
- WAIT:
  - Count cycles.
  - On i_eng_done: register o_bin_re, o_bin_im and o_bin_k = k; set o_bin_valid = 1; go to OUT.
  - If the count reaches WAIT_MAX without done: pulse o_err, go to IDLE (frame aborted, no o_frame_done).
- OUT:
  - Hold o_bin_valid and data stable until i_bin_ready. Data must not change while valid and not ready.
  - On handshake with k < N-1: k++, go to CLR.
  - On handshake with k == N-1: pulse o_frame_done, go to IDLE.
- o_eng_k and o_eng_N are stable from CLR through OUT of each bin.
- i_eng_done outside WAIT is ignored.
- i_start outside IDLE is ignored.
- Shift is arithmetic, so the sign is preserved (e.g. -64 >>> 6 = -1, -1 >>> 6 = -1).
- Per-bin latency: 1 (CLR) + N (FEED) + engine latency + 1 (capture) cycles, plus the ready stall.
- Back-to-back frames: a start in the cycle after o_frame_done is accepted.
- Reset mid-operation: immediately returns to IDLE with all outputs cleared. A partial frame is discarded; a pending o_bin_valid is dropped.

Test Plan:
- N=2, samples {-1, -1}, engine model returns (-128, 0) then (0, 0), i_bin_ready=1 -> bins k=0 (re=-2, im=0), k=1 (re=0, im=0), then o_frame_done pulse; o_eng_rst pulses twice; o_eng_wr high 2 cycles per bin with n=0,1.
- N=4 ramp {0, 64, 128, 192}, i_bin_ready held low 10 cycles on bin 2 -> o_bin_valid and data stable for all 10 cycles; no o_eng_rst until handshake; 4 results in order k=0..3.
- i_start with i_N=0, then with i_N=N_MAX+1 -> o_err pulse each time, o_busy stays 0, o_s_ready stays 0.
- i_s_valid toggling 1,0,1,0 during LOAD with N=4 -> exactly 4 samples written; FEED replays them at n=0..3 on consecutive cycles.
- Engine never asserts done, WAIT_MAX=16 -> o_err pulses 16 cycles after FEED ends, state IDLE, no o_frame_done.
- Assert i_reset mid-FEED for N=8 -> o_eng_wr, o_busy and o_bin_valid go 0 asynchronously; a new start with N=2 afterwards completes normally.

Source files
------------

// File: rtl/dft_sweep_ctrl_if.sv
// Signal bundle between the DFT sweep sequencer and its environment:
// sample source, single-bin DFT engine and result consumer.
interface dft_sweep_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             i_start;
    logic [WIDTH-1:0] i_N;
    logic             i_s_valid;
    logic [WIDTH-1:0] i_s_data;
    logic             o_s_ready;
    logic             o_eng_rst;
    logic             o_eng_wr;
    logic [WIDTH-1:0] o_eng_x;
    logic [WIDTH-1:0] o_eng_n;
    logic [WIDTH-1:0] o_eng_k;
    logic [WIDTH-1:0] o_eng_N;
    logic             i_eng_done;
    logic [WIDTH-1:0] i_eng_X_re;
    logic [WIDTH-1:0] i_eng_X_im;
    logic             o_bin_valid;
    logic             i_bin_ready;
    logic [WIDTH-1:0] o_bin_k;
    logic [WIDTH-1:0] o_bin_re;
    logic [WIDTH-1:0] o_bin_im;
    logic             o_busy;
    logic             o_frame_done;
    logic             o_err;

    // Sequencer side.
    modport master (
        input  i_start, i_N, i_s_valid, i_s_data, i_eng_done, i_eng_X_re, i_eng_X_im, i_bin_ready,
        output o_s_ready, o_eng_rst, o_eng_wr, o_eng_x, o_eng_n, o_eng_k, o_eng_N,
               o_bin_valid, o_bin_k, o_bin_re, o_bin_im, o_busy, o_frame_done, o_err
    );

    // Environment side (source, engine, consumer).
    modport slave (
        output i_start, i_N, i_s_valid, i_s_data, i_eng_done, i_eng_X_re, i_eng_X_im, i_bin_ready,
        input  o_s_ready, o_eng_rst, o_eng_wr, o_eng_x, o_eng_n, o_eng_k, o_eng_N,
               o_bin_valid, o_bin_k, o_bin_re, o_bin_im, o_busy, o_frame_done, o_err
    );
endinterface

// File: rtl/dft_sweep_ctrl.sv
// Frame sequencer for a single-bin DFT engine: buffers one frame, then for each
// bin clears the engine, replays the frame into it and hands out the scaled result.
module dft_sweep_ctrl #(
    parameter int WIDTH     = 16,
    parameter int N_MAX     = 1024,
    parameter int LOG_N_MAX = 10,
    parameter int FRAC_BITS = 6,
    parameter int WAIT_MAX  = 4096
) (
    input logic i_sys_clk,
    input logic i_reset,
    dft_sweep_ctrl_if.master bus
);
    localparam int WCW = $clog2(WAIT_MAX + 1);
    localparam logic [WIDTH-1:0]       ONE    = WIDTH'(1);
    localparam logic signed [WIDTH:0]  NMAX_S = (WIDTH+1)'(N_MAX);
    localparam logic [WCW-1:0]         WLAST  = WCW'(WAIT_MAX - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLR, S_FEED, S_WAIT, S_OUT} state_t;

    state_t state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d, k_q, k_d, len_q, len_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic             s_ready_q, s_ready_d, eng_rst_q, eng_rst_d, eng_wr_q, eng_wr_d;
    logic             bin_valid_q, bin_valid_d, busy_q, busy_d;
    logic             frame_done_q, frame_done_d, err_q, err_d;
    logic [WIDTH-1:0] bin_k_q, bin_k_d, bin_re_q, bin_re_d, bin_im_q, bin_im_d;
    logic [WIDTH-1:0] eng_x_q;

    logic [WIDTH-1:0]     mem [N_MAX];
    logic                 mem_we;
    logic [LOG_N_MAX-1:0] wr_addr, rd_addr;

    logic signed [WIDTH:0] n_in;
    logic                  start_ok, last_n, last_k;

    assign n_in     = {bus.i_N[WIDTH-1], bus.i_N};
    assign start_ok = !n_in[WIDTH] && (n_in != '0) && (n_in <= NMAX_S);
    assign last_n   = (n_q == len_q - ONE);
    assign last_k   = (k_q == len_q - ONE);
    assign wr_addr  = n_q[LOG_N_MAX-1:0];
    // Prefetch: CLR fetches sample 0, each FEED cycle fetches n+1 so the
    // registered read data lines up with o_eng_n on every write strobe.
    assign rd_addr  = (state_q == S_CLR) ? '0 : LOG_N_MAX'(n_q + ONE);

    always_ff @(posedge i_sys_clk) begin
        if (mem_we) mem[wr_addr] <= bus.i_s_data;
    end

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) eng_x_q <= '0;
        else         eng_x_q <= mem[rd_addr];
    end

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        k_d          = k_q;
        len_d        = len_q;
        wcnt_d       = wcnt_q;
        bin_valid_d  = bin_valid_q;
        bin_k_d      = bin_k_q;
        bin_re_d     = bin_re_q;
        bin_im_d     = bin_im_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        mem_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    if (start_ok) begin
                        len_d   = bus.i_N;
                        n_d     = '0;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (bus.i_s_valid && s_ready_q) begin
                    mem_we = 1'b1;
                    if (last_n) begin
                        k_d     = '0;
                        state_d = S_CLR;
                    end else begin
                        n_d = n_q + ONE;
                    end
                end
            end
            S_CLR: begin
                n_d     = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (last_n) begin
                    wcnt_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    n_d = n_q + ONE;
                end
            end
            S_WAIT: begin
                if (bus.i_eng_done) begin
                    bin_k_d     = k_q;
                    bin_re_d    = WIDTH'($signed(bus.i_eng_X_re) >>> FRAC_BITS);
                    bin_im_d    = WIDTH'($signed(bus.i_eng_X_im) >>> FRAC_BITS);
                    bin_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else if (wcnt_q == WLAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            S_OUT: begin
                if (bus.i_bin_ready) begin
                    bin_valid_d = 1'b0;
                    if (last_k) begin
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        k_d     = k_q + ONE;
                        state_d = S_CLR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Level outputs are registered copies of the next-state decode.
        s_ready_d = (state_d == S_LOAD);
        eng_rst_d = (state_d == S_CLR);
        eng_wr_d  = (state_d == S_FEED);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            k_q          <= '0;
            len_q        <= '0;
            wcnt_q       <= '0;
            s_ready_q    <= 1'b0;
            eng_rst_q    <= 1'b0;
            eng_wr_q     <= 1'b0;
            bin_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            bin_k_q      <= '0;
            bin_re_q     <= '0;
            bin_im_q     <= '0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            k_q          <= k_d;
            len_q        <= len_d;
            wcnt_q       <= wcnt_d;
            s_ready_q    <= s_ready_d;
            eng_rst_q    <= eng_rst_d;
            eng_wr_q     <= eng_wr_d;
            bin_valid_q  <= bin_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            bin_k_q      <= bin_k_d;
            bin_re_q     <= bin_re_d;
            bin_im_q     <= bin_im_d;
        end
    end

    assign bus.o_s_ready    = s_ready_q;
    assign bus.o_eng_rst    = eng_rst_q;
    assign bus.o_eng_wr     = eng_wr_q;
    assign bus.o_eng_x      = eng_x_q;
    assign bus.o_eng_n      = n_q;
    assign bus.o_eng_k      = k_q;
    assign bus.o_eng_N      = len_q;
    assign bus.o_bin_valid  = bin_valid_q;
    assign bus.o_bin_k      = bin_k_q;
    assign bus.o_bin_re     = bin_re_q;
    assign bus.o_bin_im     = bin_im_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_frame_done = frame_done_q;
    assign bus.o_err        = err_q;
endmodule

// File: tb/tb_dft_sweep_ctrl.sv
// Bench for dft_sweep_ctrl: behavioural engine and consumer models plus
// scenario tasks driving randomized frames.
module tb_dft_sweep_ctrl;
    localparam int W = 16, NMAX = 16, LOGN = 4, FB = 6, WMAX = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dft_sweep_ctrl_if #(.WIDTH(W)) bus ();
    dft_sweep_ctrl #(.WIDTH(W), .N_MAX(NMAX), .LOG_N_MAX(LOGN), .FRAC_BITS(FB), .WAIT_MAX(WMAX))
        dut (.i_sys_clk(clk), .i_reset(rst), .bus(bus));

    int checks = 0, errors = 0;

    typedef struct { int k; int re; int im; } bin_t;
    bin_t expq[$];
    int frame [NMAX];
    int fix_re [NMAX], fix_im [NMAX];
    int got_k [64], got_re [64], got_im [64];
    int frame_len = 0, cyc = 0;
    int rst_cnt, wr_cnt, feed_bad, gap_bad, hs_cnt, done_cnt, err_cnt, stall_cnt, rst_in_valid;
    int feed_end_cyc, err_cyc, lat, lat_cfg = 0, rdy_mode = 0, stall_k = 0, stall_left = 0;
    bit prev_wr, pending, mute = 0, fixed_mode = 0, prev_stall;
    logic [W-1:0] held_k, held_re, held_im;

    // Floor division by 2**FB: what an arithmetic right shift must produce.
    function automatic int scale(int v);
        int d = 1 << FB;
        return (v < 0) ? -((-v + d - 1) / d) : v / d;
    endfunction

    function automatic int rnd_s();
        logic signed [W-1:0] t;
        t = W'($urandom);
        return int'(t);
    endfunction

    // Engine + consumer model, sampling registered DUT outputs 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        bus.i_eng_done = 1'b0;
        if (rst) begin
            pending = 0; prev_wr = 0; prev_stall = 0;
            bus.i_bin_ready = 1'b0; bus.i_eng_X_re = '0; bus.i_eng_X_im = '0;
        end else begin
            if (bus.o_eng_rst) begin
                rst_cnt++; wr_cnt = 0; pending = 0;
                if (bus.o_bin_valid) rst_in_valid++;
            end
            if (bus.o_eng_wr) begin
                if (wr_cnt > 0 && !prev_wr) gap_bad++;
                if (wr_cnt >= frame_len) feed_bad++;
                else if (bus.o_eng_n !== W'(wr_cnt) || bus.o_eng_x !== W'(frame[wr_cnt]) ||
                         bus.o_eng_k !== W'(rst_cnt - 1) || bus.o_eng_N !== W'(frame_len)) feed_bad++;
                wr_cnt++;
            end else if (prev_wr) begin
                feed_end_cyc = cyc;
                if (wr_cnt == frame_len) begin
                    pending = 1;
                    lat = (lat_cfg < 0) ? $urandom_range(0, 5) : lat_cfg;
                end
            end
            prev_wr = bus.o_eng_wr;
            if (bus.o_err) begin err_cnt++; err_cyc = cyc; end
            if (bus.o_frame_done) done_cnt++;
            if (pending && !mute) begin
                if (lat == 0) begin
                    bin_t e;
                    int r, i;
                    r = fixed_mode ? fix_re[rst_cnt-1] : rnd_s();
                    i = fixed_mode ? fix_im[rst_cnt-1] : rnd_s();
                    bus.i_eng_done = 1'b1;
                    bus.i_eng_X_re = W'(r);
                    bus.i_eng_X_im = W'(i);
                    e.k = rst_cnt - 1; e.re = scale(r); e.im = scale(i);
                    expq.push_back(e);
                    pending = 0;
                end else lat--;
            end
            if (bus.o_bin_valid) begin
                bit rdy;
                if (prev_stall) begin
                    checks++;
                    if (bus.o_bin_k !== held_k || bus.o_bin_re !== held_re || bus.o_bin_im !== held_im) begin
                        errors++;
                        $display("FAIL bin_stable: got k=%0d re=%0d im=%0d, required k=%0d re=%0d im=%0d",
                                 bus.o_bin_k, $signed(bus.o_bin_re), $signed(bus.o_bin_im),
                                 held_k, $signed(held_re), $signed(held_im));
                    end
                end
                if (rdy_mode == 2 && bus.o_bin_k == W'(stall_k) && stall_left > 0) begin
                    rdy = 0; stall_left--; stall_cnt++;
                end else if (rdy_mode == 1) rdy = 1'($urandom_range(0, 1));
                else rdy = 1;
                bus.i_bin_ready = rdy;
                if (rdy) begin
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL bin_unexpected: got k=%0d, required no result", bus.o_bin_k);
                    end else begin
                        bin_t e;
                        e = expq.pop_front();
                        if (bus.o_bin_k !== W'(e.k) || bus.o_bin_re !== W'(e.re) || bus.o_bin_im !== W'(e.im)) begin
                            errors++;
                            $display("FAIL bin_data: got k=%0d re=%0d im=%0d, required k=%0d re=%0d im=%0d",
                                     bus.o_bin_k, $signed(bus.o_bin_re), $signed(bus.o_bin_im), e.k, e.re, e.im);
                        end
                    end
                    if (hs_cnt < 64) begin
                        got_k[hs_cnt]  = int'(bus.o_bin_k);
                        got_re[hs_cnt] = int'($signed(bus.o_bin_re));
                        got_im[hs_cnt] = int'($signed(bus.o_bin_im));
                    end
                    hs_cnt++;
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    held_k = bus.o_bin_k; held_re = bus.o_bin_re; held_im = bus.o_bin_im;
                end
            end else begin
                if (prev_stall) begin
                    checks++; errors++;
                    $display("FAIL bin_dropped: got valid=0, required valid=1 while stalled");
                end
                prev_stall = 0;
                bus.i_bin_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic clear_model(int n);
        rst_cnt = 0; wr_cnt = 0; feed_bad = 0; gap_bad = 0; hs_cnt = 0; done_cnt = 0;
        err_cnt = 0; stall_cnt = 0; rst_in_valid = 0; frame_len = n;
        expq.delete();
    endtask

    task automatic start_frame(int n);
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_N = W'(n);
        @(negedge clk);
        bus.i_start = 1'b0;
        checks++;
        if (bus.o_busy !== 1'b1 || bus.o_s_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_accept N=%0d: got busy=%b ready=%b, required 1 1", n, bus.o_busy, bus.o_s_ready);
        end
    endtask

    // vmode: 0 valid held, 1 toggling 1,0,1,0, 2 random.
    task automatic load(int n, int vmode);
        int got = 0;
        bit hs;
        for (int g = 0; g < 400 && got < n; g++) begin
            case (vmode)
                0: bus.i_s_valid = 1'b1;
                1: bus.i_s_valid = (g % 2 == 0);
                default: bus.i_s_valid = 1'($urandom_range(0, 1));
            endcase
            bus.i_s_data = W'(frame[got]);
            hs = bus.i_s_valid && bus.o_s_ready;
            @(negedge clk);
            if (hs) got++;
        end
        bus.i_s_valid = 1'b0;
        checks++;
        if (got != n || bus.o_s_ready !== 1'b0) begin
            errors++;
            $display("FAIL load: got %0d samples ready=%b, required %0d samples ready=0", got, bus.o_s_ready, n);
        end
    endtask

    task automatic wait_frame(int n);
        int c = 0;
        while (done_cnt == 0 && c < 3000) begin @(negedge clk); c++; end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL frame_timeout: got no o_frame_done in %0d cycles, required one", c);
        end
        checks++;
        if (hs_cnt != n || rst_cnt != n || feed_bad != 0 || gap_bad != 0 || done_cnt != 1 ||
            expq.size() != 0 || rst_in_valid != 0 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL frame N=%0d: got bins=%0d rst=%0d feed_bad=%0d gaps=%0d done=%0d left=%0d rst_in_valid=%0d busy=%b, required %0d %0d 0 0 1 0 0 0",
                     n, hs_cnt, rst_cnt, feed_bad, gap_bad, done_cnt, expq.size(), rst_in_valid, bus.o_busy, n, n);
        end
    endtask

    task automatic run_frame(int n, int vmode, bit keep);
        if (!keep) for (int i = 0; i < n; i++) frame[i] = rnd_s();
        clear_model(n);
        start_frame(n);
        load(n, vmode);
        wait_frame(n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_start = 0; bus.i_N = '0; bus.i_s_valid = 0; bus.i_s_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.o_busy !== 0 || bus.o_s_ready !== 0 || bus.o_eng_rst !== 0 || bus.o_eng_wr !== 0 ||
            bus.o_bin_valid !== 0 || bus.o_frame_done !== 0 || bus.o_err !== 0 || bus.o_eng_N !== '0 ||
            bus.o_eng_k !== '0 || bus.o_eng_n !== '0 || bus.o_eng_x !== '0 || bus.o_bin_re !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b rdy=%b erst=%b wr=%b bv=%b N=%0d x=%0d, required all 0",
                     bus.o_busy, bus.o_s_ready, bus.o_eng_rst, bus.o_eng_wr, bus.o_bin_valid, bus.o_eng_N, bus.o_eng_x);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        frame[0] = -1; frame[1] = -1;
        fix_re[0] = -128; fix_im[0] = 0; fix_re[1] = 0; fix_im[1] = 0;
        fixed_mode = 1; rdy_mode = 0; lat_cfg = 2;
        run_frame(2, 0, 1);
        checks++;
        if (got_k[0] != 0 || got_re[0] != -2 || got_im[0] != 0 || got_k[1] != 1 || got_re[1] != 0 || got_im[1] != 0) begin
            errors++;
            $display("FAIL basic_bins: got (%0d,%0d,%0d)(%0d,%0d,%0d), required (0,-2,0)(1,0,0)",
                     got_k[0], got_re[0], got_im[0], got_k[1], got_re[1], got_im[1]);
        end
        fixed_mode = 0;
    endtask

    task automatic test_shift();
        int ere [4] = '{-1, -1, 0, -512};
        int eim [4] = '{1, -2, 511, 1};
        fix_re[0] = -64; fix_re[1] = -1;  fix_re[2] = 63;    fix_re[3] = -32768;
        fix_im[0] = 64;  fix_im[1] = -65; fix_im[2] = 32767; fix_im[3] = 127;
        fixed_mode = 1; rdy_mode = 0; lat_cfg = 0;
        run_frame(4, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_re[i] != ere[i] || got_im[i] != eim[i]) begin
                errors++;
                $display("FAIL shift bin %0d: got re=%0d im=%0d, required re=%0d im=%0d", i, got_re[i], got_im[i], ere[i], eim[i]);
            end
        end
        fixed_mode = 0;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) frame[i] = 64 * i;
        rdy_mode = 2; stall_k = 2; stall_left = 10; lat_cfg = 1;
        run_frame(4, 0, 1);
        checks++;
        if (stall_cnt != 10 || got_k[0] != 0 || got_k[1] != 1 || got_k[2] != 2 || got_k[3] != 3) begin
            errors++;
            $display("FAIL stall: got stall=%0d order=%0d%0d%0d%0d, required stall=10 order=0123",
                     stall_cnt, got_k[0], got_k[1], got_k[2], got_k[3]);
        end
        rdy_mode = 0;
    endtask

    task automatic test_bad_start();
        int bad [3] = '{0, NMAX + 1, -3};
        for (int i = 0; i < 3; i++) begin
            clear_model(0);
            @(negedge clk);
            bus.i_start = 1'b1; bus.i_N = W'(bad[i]);
            @(negedge clk);
            bus.i_start = 1'b0;
            checks++;
            if (bus.o_err !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_s_ready !== 1'b0) begin
                errors++;
                $display("FAIL bad_start N=%0d: got err=%b busy=%b ready=%b, required 1 0 0", bad[i], bus.o_err, bus.o_busy, bus.o_s_ready);
            end
            @(negedge clk);
            checks++;
            if (bus.o_err !== 1'b0 || bus.o_busy !== 1'b0 || err_cnt != 1) begin
                errors++;
                $display("FAIL bad_start_pulse N=%0d: got err=%b busy=%b pulses=%0d, required 0 0 1", bad[i], bus.o_err, bus.o_busy, err_cnt);
            end
        end
    endtask

    task automatic test_timeout();
        int c = 0;
        mute = 1;
        for (int i = 0; i < 3; i++) frame[i] = rnd_s();
        clear_model(3);
        start_frame(3);
        load(3, 0);
        while (err_cnt == 0 && c < 200) begin @(negedge clk); c++; end
        repeat (3) @(negedge clk);
        checks++;
        if (err_cnt != 1 || err_cyc - feed_end_cyc != WMAX) begin
            errors++;
            $display("FAIL timeout_err: got pulses=%0d delay=%0d, required 1 %0d", err_cnt, err_cyc - feed_end_cyc, WMAX);
        end
        checks++;
        if (bus.o_busy !== 1'b0 || done_cnt != 0 || bus.o_bin_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: got busy=%b done=%0d valid=%b, required 0 0 0", bus.o_busy, done_cnt, bus.o_bin_valid);
        end
        mute = 0;
    endtask

    task automatic test_reset_mid();
        int c = 0;
        lat_cfg = 0;
        for (int i = 0; i < 8; i++) frame[i] = rnd_s();
        clear_model(8);
        start_frame(8);
        load(8, 0);
        while (bus.o_eng_wr !== 1'b1 && c < 20) begin @(negedge clk); c++; end
        @(negedge clk);
        checks++;
        if (bus.o_eng_wr !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_feed: got wr=%b, required 1 before reset", bus.o_eng_wr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.o_eng_wr !== 0 || bus.o_busy !== 0 || bus.o_bin_valid !== 0 || bus.o_eng_N !== '0) begin
            errors++;
            $display("FAIL reset_async: got wr=%b busy=%b valid=%b N=%0d, required 0 0 0 0",
                     bus.o_eng_wr, bus.o_busy, bus.o_bin_valid, bus.o_eng_N);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame(2, 2, 0);
    endtask

    task automatic test_back_to_back();
        lat_cfg = -1; rdy_mode = 1;
        run_frame(3, 2, 0);
        run_frame(5, 2, 0);
    endtask

    task automatic test_random();
        lat_cfg = -1; rdy_mode = 1;
        for (int r = 0; r < 6; r++) run_frame($urandom_range(1, NMAX), 2, 0);
        rdy_mode = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift();
        test_stall();
        test_bad_start();
        clear_model(4);
        for (int i = 0; i < 4; i++) frame[i] = rnd_s();
        lat_cfg = 1;
        start_frame(4);
        load(4, 1);
        wait_frame(4);
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
